// File: rtl/mdu_defs.sv
// Shared definitions for the iterative multiply/divide unit and the decoder that issues to it.
package mdu_defs;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_OP_W  = 7;

    localparam int MDU_MUL   = 0;
    localparam int MDU_MULH  = 1;
    localparam int MDU_MULHU = 2;
    localparam int MDU_DIV   = 3;
    localparam int MDU_MOD   = 4;
    localparam int MDU_DIVU  = 5;
    localparam int MDU_MODU  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider with valid/ready request and result handshakes.
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   CALC  | one product/quotient bit per cycle for WIDTH cycles
//   DONE  | result held on mdu_result until out_ready
module mul_div_unit
    import mdu_defs::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [WIDTH-1:0]    mdu_src1,
    input  logic [WIDTH-1:0]    mdu_src2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    mdu_result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   opnd_q, res_q;
    logic               is_mul_q, sel_lo_q, sign_q;

    logic                accept;
    logic [MDU_OP_W-1:0] op_in;
    logic                is_mul_in, signed_in, s1, s2, sign_in, div_zero;
    logic [WIDTH-1:0]    abs1, abs2, zero_res;
    logic [WIDTH:0]      mul_sum, div_shift;
    logic                div_take;
    logic [WIDTH-1:0]    div_rem;
    logic [2*WIDTH-1:0]  step, mul_full;
    logic [WIDTH-1:0]    mul_word, div_word, final_res;

    // Request decode; a malformed opcode falls back to a plain signed multiply.
    always_comb begin
        accept    = in_valid & (state_q == ST_IDLE) & ~flush;
        op_in     = $onehot(mdu_op) ? mdu_op : MDU_OP_W'(1);
        is_mul_in = op_in[MDU_MUL] | op_in[MDU_MULH] | op_in[MDU_MULHU];
        signed_in = op_in[MDU_MUL] | op_in[MDU_MULH] | op_in[MDU_DIV] | op_in[MDU_MOD];
        s1        = signed_in & mdu_src1[WIDTH-1];
        s2        = signed_in & mdu_src2[WIDTH-1];
        abs1      = s1 ? -mdu_src1 : mdu_src1;
        abs2      = s2 ? -mdu_src2 : mdu_src2;
        sign_in   = (op_in[MDU_MOD] | op_in[MDU_MODU]) ? s1 : (s1 ^ s2);
        div_zero  = ~is_mul_in & (mdu_src2 == '0);
        zero_res  = (op_in[MDU_DIV] | op_in[MDU_DIVU]) ? '1 : mdu_src1;
    end

    // prod_q holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum   = prod_q[0] ? ({1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                              : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_take  = (div_shift >= {1'b0, opnd_q});
        div_rem   = div_take ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
        step      = is_mul_q ? {mul_sum, prod_q[WIDTH-1:1]}
                             : {div_rem, prod_q[WIDTH-2:0], div_take};
        mul_full  = sign_q ? -step : step;
        mul_word  = sel_lo_q ? mul_full[WIDTH-1:0] : mul_full[2*WIDTH-1:WIDTH];
        div_word  = sel_lo_q ? step[WIDTH-1:0] : step[2*WIDTH-1:WIDTH];
        final_res = is_mul_q ? mul_word : (sign_q ? -div_word : div_word);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) state_d = div_zero ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_DONE;
                ST_DONE: if (out_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        out_valid  = (state_q == ST_DONE);
        mdu_result = res_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            res_q    <= '0;
            is_mul_q <= 1'b0;
            sel_lo_q <= 1'b0;
            sign_q   <= 1'b0;
        end else if (accept) begin
            cnt_q    <= '0;
            is_mul_q <= is_mul_in;
            sel_lo_q <= op_in[MDU_MUL] | op_in[MDU_DIV] | op_in[MDU_DIVU];
            sign_q   <= sign_in;
            opnd_q   <= is_mul_in ? abs1 : abs2;
            prod_q   <= {{WIDTH{1'b0}}, (is_mul_in ? abs2 : abs1)};
            if (div_zero) res_q <= zero_res;
        end else if (state_q == ST_CALC && !flush) begin
            prod_q <= step;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) res_q <= final_res;
        end
    end

endmodule
